// File: rtl/fwd_hazard_scoreboard.sv
// EX operand forwarding plus ID-stage hazard detection (load-use, long-latency scoreboard, capacity).
// Optional macro FWD_LL_BYPASS_EN lets a same-cycle long-latency completion release dependent stalls.
module fwd_hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned FSEL_W = $clog2(NUM_FWD + 1),
  localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1),
  localparam int unsigned NREG   = 2 ** AW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*AW-1:0]     ex_rs,
  input  logic [NUM_FWD*AW-1:0]     fwd_rd,
  input  logic [NUM_FWD-1:0]        fwd_we,
  output logic [NUM_SRC*FSEL_W-1:0] fwd_sel,
  input  logic                      id_valid,
  input  logic                      id_flush,
  input  logic [NUM_SRC*AW-1:0]     id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [AW-1:0]             id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_ll,
  input  logic [AW-1:0]             idex_rd,
  input  logic                      idex_mem_read,
  input  logic                      ll_done_valid,
  input  logic [AW-1:0]             ll_done_rd,
  output logic                      id_stall,
  output logic [NREG-1:0]           busy_vec,
  output logic [OUT_W-1:0]          outstanding,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      sb_err
);

  logic            found;
  logic [NREG-1:0] done_mask;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] busy_nxt;
  logic            done_ok;
  logic            slot_free;
  logic            hz_load_use;
  logic            hz_raw;
  logic            hz_waw;
  logic            hz_cap;
  logic            issue;
  logic            err_set;

  // Forwarding select: youngest matching stage wins, x0 never forwarded
  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_FWD; k++) begin
        if (!found && fwd_we[k] && (fwd_rd[k*AW +: AW] != '0) &&
            (fwd_rd[k*AW +: AW] == ex_rs[i*AW +: AW])) begin
          fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
          found = 1'b1;
        end
      end
    end
  end

  assign done_ok = ll_done_valid && (ll_done_rd != '0) && busy_vec[ll_done_rd];

  always_comb begin
    done_mask = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      done_mask[r] = ll_done_valid && (ll_done_rd == AW'(r));
    end
  end

`ifdef FWD_LL_BYPASS_EN
  assign busy_eff  = busy_vec & ~done_mask;
  assign slot_free = (outstanding != OUT_W'(MAX_OUT)) || done_ok;
`else
  assign busy_eff  = busy_vec;
  assign slot_free = (outstanding != OUT_W'(MAX_OUT));
`endif

  // Hazard detection against the instruction sitting in ID
  always_comb begin
    hz_load_use = 1'b0;
    hz_raw      = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*AW +: AW] == idex_rd)) begin
        hz_load_use = 1'b1;
      end
      if (id_rs_used[i] && (id_rs[i*AW +: AW] != '0) && busy_eff[id_rs[i*AW +: AW]]) begin
        hz_raw = 1'b1;
      end
    end
    hz_load_use = hz_load_use && idex_mem_read && (idex_rd != '0) && id_valid;
    hz_raw      = hz_raw && id_valid;
    hz_waw      = id_valid && id_rd_we && (id_rd != '0) && busy_eff[id_rd];
    hz_cap      = id_valid && id_is_ll && !slot_free;
  end

  assign id_stall = (hz_load_use || hz_raw || hz_waw || hz_cap) && !id_flush && !rst;
  assign issue    = id_valid && !id_flush && !id_stall && id_is_ll && id_rd_we && (id_rd != '0);
  assign err_set  = (ll_done_valid && !done_ok) || (issue && ll_done_valid && (ll_done_rd == id_rd));

  // Issue applied after completion so a same-rd collision leaves the bit set
  always_comb begin
    busy_nxt = busy_vec;
    if (done_ok) busy_nxt[ll_done_rd] = 1'b0;
    if (issue)   busy_nxt[id_rd]      = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec    <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
      sb_err      <= 1'b0;
    end else begin
      busy_vec    <= busy_nxt;
      outstanding <= outstanding + OUT_W'(issue) - OUT_W'(done_ok);
      if (id_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (err_set) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed scoreboard bench for fwd_hazard_scoreboard (AW=5, NUM_SRC=2, NUM_FWD=2, MAX_OUT=2, CNT_W=4).
// Expectations follow FWD_LL_BYPASS_EN when it is defined for the build.
module tb_fwd_hazard_scoreboard;

`ifdef FWD_LL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  ex_rs;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_we;
  logic [3:0]  fwd_sel;
  logic        id_valid;
  logic        id_flush;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_rd_we;
  logic        id_is_ll;
  logic [4:0]  idex_rd;
  logic        idex_mem_read;
  logic        ll_done_valid;
  logic [4:0]  ll_done_rd;
  logic        id_stall;
  logic [31:0] busy_vec;
  logic [1:0]  outstanding;
  logic [3:0]  stall_cnt;
  logic        sb_err;

  fwd_hazard_scoreboard #(.AW(5), .NUM_SRC(2), .NUM_FWD(2), .MAX_OUT(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .ex_rs(ex_rs), .fwd_rd(fwd_rd), .fwd_we(fwd_we), .fwd_sel(fwd_sel),
    .id_valid(id_valid), .id_flush(id_flush), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_ll(id_is_ll), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ll_done_valid(ll_done_valid), .ll_done_rd(ll_done_rd),
    .id_stall(id_stall), .busy_vec(busy_vec), .outstanding(outstanding),
    .stall_cnt(stall_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  sel;
    logic        stall;
    logic [31:0] busy;
    logic [1:0]  outs;
    logic [3:0]  cnt;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_busy;
  logic [1:0]  exp_out;
  logic [3:0]  exp_cnt;
  logic        exp_err;

  // Pop one expectation per cycle and compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      assert (fwd_sel === e.sel) else begin
        n_fail++; $error("FAIL %s fwd_sel got %b exp %b", e.tag, fwd_sel, e.sel);
      end
      n_tests++;
      assert (id_stall === e.stall) else begin
        n_fail++; $error("FAIL %s id_stall got %b exp %b", e.tag, id_stall, e.stall);
      end
      n_tests++;
      assert (busy_vec === e.busy) else begin
        n_fail++; $error("FAIL %s busy_vec got %h exp %h", e.tag, busy_vec, e.busy);
      end
      n_tests++;
      assert (outstanding === e.outs) else begin
        n_fail++; $error("FAIL %s outstanding got %0d exp %0d", e.tag, outstanding, e.outs);
      end
      n_tests++;
      assert (stall_cnt === e.cnt) else begin
        n_fail++; $error("FAIL %s stall_cnt got %0d exp %0d", e.tag, stall_cnt, e.cnt);
      end
      n_tests++;
      assert (sb_err === e.err) else begin
        n_fail++; $error("FAIL %s sb_err got %b exp %b", e.tag, sb_err, e.err);
      end
    end
  end

  task automatic idle();
    ex_rs = '0; fwd_rd = '0; fwd_we = '0;
    id_valid = 1'b0; id_flush = 1'b0; id_rs = '0; id_rs_used = '0;
    id_rd = '0; id_rd_we = 1'b0; id_is_ll = 1'b0;
    idex_rd = '0; idex_mem_read = 1'b0;
    ll_done_valid = 1'b0; ll_done_rd = '0;
  endtask

  // Push the expectation for the cycle just driven, then advance one clock
  task automatic step(input string tag, input logic [3:0] sel, input logic stl);
    q.push_back('{tag, sel, stl, exp_busy, exp_out, exp_cnt, exp_err});
    @(posedge clk); #1;
    if (stl && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    exp_busy = '0; exp_out = '0; exp_cnt = '0; exp_err = 1'b0;
    @(posedge clk); #1;

    // Hazard present during reset must not stall
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_valid = 1'b1; id_rs = 10'd7; id_rs_used = 2'b01;
    step("rst_stall_mask", 4'b0000, 1'b0);
    rst = 1'b0;
    idle();

    // Forwarding priority
    ex_rs = {5'd6, 5'd5}; fwd_rd = {5'd5, 5'd5}; fwd_we = 2'b11;
    step("fwd_young", 4'b0001, 1'b0);
    fwd_we = 2'b10;
    step("fwd_old", 4'b0010, 1'b0);
    fwd_rd = {5'd5, 5'd6}; fwd_we = 2'b11;
    step("fwd_two_ops", 4'b0110, 1'b0);
    ex_rs = '0; fwd_rd = '0; fwd_we = 2'b11;
    step("fwd_x0", 4'b0000, 1'b0);
    idle();

    // Load-use
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_valid = 1'b1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    step("lu_stall", 4'b0000, 1'b1);
    idex_mem_read = 1'b0; idex_rd = 5'd0;
    step("lu_release", 4'b0000, 1'b0);
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_rs_used = 2'b00;
    step("lu_unused", 4'b0000, 1'b0);
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    step("lu_op1", 4'b0000, 1'b1);
    idle();

    // Long-latency issue and dependent RAW stall
    id_valid = 1'b1; id_is_ll = 1'b1; id_rd_we = 1'b1; id_rd = 5'd10;
    step("ll_issue", 4'b0000, 1'b0);
    exp_busy[10] = 1'b1; exp_out = 2'd1;
    idle();
    id_valid = 1'b1; id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01; id_rd_we = 1'b1; id_rd = 5'd11;
    step("raw_stall0", 4'b0000, 1'b1);
    step("raw_stall1", 4'b0000, 1'b1);
    ll_done_valid = 1'b1; ll_done_rd = 5'd10;
    step("raw_done", 4'b0000, !BYP);
    exp_busy[10] = 1'b0; exp_out = 2'd0;
    ll_done_valid = 1'b0;
    step("raw_after", 4'b0000, 1'b0);
    idle();

    // Capacity with MAX_OUT=2
    id_valid = 1'b1; id_is_ll = 1'b1; id_rd_we = 1'b1; id_rd = 5'd1;
    step("cap_i1", 4'b0000, 1'b0);
    exp_busy[1] = 1'b1; exp_out = 2'd1;
    id_rd = 5'd2;
    step("cap_i2", 4'b0000, 1'b0);
    exp_busy[2] = 1'b1; exp_out = 2'd2;
    id_rd = 5'd3;
    step("cap_full", 4'b0000, 1'b1);
    ll_done_valid = 1'b1; ll_done_rd = 5'd1;
    step("cap_done", 4'b0000, !BYP);
    exp_busy[1] = 1'b0;
    if (BYP) exp_busy[3] = 1'b1;
    else     exp_out = 2'd1;
    ll_done_valid = 1'b0;
    // Bypass build: x3 already issued so this is a WAW stall; otherwise the issue proceeds now
    step("cap_retry", 4'b0000, BYP);
    if (!BYP) begin
      exp_busy[3] = 1'b1; exp_out = 2'd2;
    end
    id_is_ll = 1'b0; id_rd = 5'd2;
    step("waw", 4'b0000, 1'b1);
    idle();
    ll_done_valid = 1'b1; ll_done_rd = 5'd2;
    step("done2", 4'b0000, 1'b0);
    exp_busy[2] = 1'b0; exp_out = exp_out - 2'd1;
    ll_done_rd = 5'd3;
    step("done3", 4'b0000, 1'b0);
    exp_busy[3] = 1'b0; exp_out = exp_out - 2'd1;
    idle();

    // Flush masks stall and suppresses issue
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_valid = 1'b1; id_rs = 10'd7; id_rs_used = 2'b01;
    id_is_ll = 1'b1; id_rd_we = 1'b1; id_rd = 5'd12; id_flush = 1'b1;
    step("flush", 4'b0000, 1'b0);
    idle();
    step("flush_noissue", 4'b0000, 1'b0);

    // Spurious completion is sticky
    ll_done_valid = 1'b1; ll_done_rd = 5'd9;
    step("err_nonbusy", 4'b0000, 1'b0);
    exp_err = 1'b1;
    ll_done_valid = 1'b0;
    step("err_sticky", 4'b0000, 1'b0);

    // In-flight op that reset will discard
    id_valid = 1'b1; id_is_ll = 1'b1; id_rd_we = 1'b1; id_rd = 5'd4;
    step("ll_issue4", 4'b0000, 1'b0);
    exp_busy[4] = 1'b1; exp_out = 2'd1;
    idle();

    // Held load-use stall saturates the 4-bit counter
    idex_mem_read = 1'b1; idex_rd = 5'd7; id_valid = 1'b1; id_rs = 10'd7; id_rs_used = 2'b01;
    for (int i = 0; i < 20; i++) step("sat", 4'b0000, 1'b1);

    rst = 1'b1;
    step("rst_pulse", 4'b0000, 1'b0);
    exp_busy = '0; exp_out = '0; exp_cnt = '0; exp_err = 1'b0;
    rst = 1'b0;
    idle();
    step("post_rst_clear", 4'b0000, 1'b0);
    ll_done_valid = 1'b1; ll_done_rd = 5'd4;
    step("post_rst_done", 4'b0000, 1'b0);
    exp_err = 1'b1;
    ll_done_valid = 1'b0;
    step("final", 4'b0000, 1'b0);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
